// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: hardware sequencer for the "program 3" pattern search.
// While busy it owns the data memory port. It reads a 5-bit pattern and a
// byte message, counts pattern occurrences three ways, and writes the three
// counts back to memory.
module pattern_scan_ctrl #(
  parameter int N_BYTES  = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       busy,
  output logic       done
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_PAT,
    S_SCAN,
    S_WR_B,
    S_WR_O,
    S_WR_S,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [4:0]       pat;
  logic [7:0]       prev;
  logic [7:0]       ctb;    // in-byte window matches
  logic [7:0]       cto;    // bytes containing at least one match
  logic [7:0]       cts;    // whole-stream window matches
  logic [11:0]      w;      // last 4 bits of the previous byte followed by the current byte
  logic [2:0]       n_in;
  logic [2:0]       n_cross;
  logic [2:0]       n_cross_gated;

  assign w = {prev[3:0], mem_rd_data};

  // Count pattern hits in the four in-byte windows and the four windows that straddle the previous byte.
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no path can leave it unassigned and infer a latch.
    n_in    = '0;
    n_cross = '0;
    for (int k = 0; k < 4; k++) begin
      if (mem_rd_data[k +: 5] == pat) n_in    = n_in + 3'd1;
      if (w[k + 4 +: 5] == pat)       n_cross = n_cross + 3'd1;
    end
  end

  // Byte 0 has no predecessor, so it contributes no straddling windows.
  assign n_cross_gated = (idx != '0) ? n_cross : 3'd0;

  // State register, scan index, pattern latch and match counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      pat   <= '0;
      prev  <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          // A new job starts from clean counters, including a restart out of DONE.
          if (start) begin
            idx  <= '0;
            prev <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
          end
        end
        S_LD_PAT: begin
          pat <= mem_rd_data[7:3];
          idx <= '0;
        end
        S_SCAN: begin
          ctb  <= ctb + 8'(n_in);
          cto  <= cto + {7'd0, (n_in != 3'd0)};
          cts  <= cts + 8'(n_in) + 8'(n_cross_gated);
          prev <= mem_rd_data;
          idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and memory-port / status outputs.
  always_comb begin
    state_nxt   = state;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LD_PAT;
      end
      S_LD_PAT: begin
        mem_addr  = 8'(PAT_ADDR);
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        mem_addr = 8'(idx);
        if (idx == IDX_LAST) state_nxt = S_WR_B;
      end
      S_WR_B: begin
        mem_addr    = 8'(RES_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb;
        state_nxt   = S_WR_O;
      end
      S_WR_O: begin
        mem_addr    = 8'(RES_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto;
        state_nxt   = S_WR_S;
      end
      S_WR_S: begin
        mem_addr    = 8'(RES_ADDR + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = S_LD_PAT;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: a behavioural 256-byte memory, a table of
// message/pattern vectors with hand-computed counts, and directed sequences
// for restart-from-DONE, reset mid-scan and start-while-busy.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done)
  );

  // Memory model: combinational read, write on rising edge. The bench stages
  // an image in img[] and copies it in with a one-cycle load pulse.
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load = 1'b0;
  int         wr_count = 0;

  assign mem_rd_data = mem[mem_addr];

  // Memory write port shared by the image loader and the DUT.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wr_count <= 0;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Message: bytes 0..31 = fill, then byte 0 / byte 1 overridden; mem[32] = pattern byte.
  typedef struct {
    string      name;
    logic [7:0] fill;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] pat_byte;
    int         ctb;
    int         cto;
    int         cts;
  } vec_t;

  vec_t vecs[6];

  task automatic build(input logic [7:0] fill, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] pat_byte);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < 32; i++)  img[i] = fill;
    img[0]  = b0;
    img[1]  = b1;
    img[32] = pat_byte;
    img[33] = 8'hEE;
    img[34] = 8'hEE;
    img[35] = 8'hEE;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  // Pulse start, count rising edges (including the one that samples start)
  // until done, then check latency, results and number of writes.
  task automatic run_job(input string name, input int e_ctb, input int e_cto,
                         input int e_cts, input bit mid_start);
    int edges;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    edges = 1;
    while (!done && edges < 100) begin
      start = (mid_start && edges == 8) ? 1'b1 : 1'b0;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({name, " latency"}, edges, 37);
    check({name, " ctb"}, int'(mem[33]), e_ctb);
    check({name, " cto"}, int'(mem[34]), e_cto);
    check({name, " cts"}, int'(mem[35]), e_cts);
    check({name, " writes"}, wr_count, 3);
    check({name, " idle wr_en"}, int'(mem_wr_en), 0);
    check({name, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    vecs[0] = '{"zeros_pat00",  8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    vecs[1] = '{"x55_pat10101", 8'h55, 8'h55, 8'h55, 8'hA8,  64, 32, 126};
    vecs[2] = '{"f8_first",     8'h00, 8'hF8, 8'h00, 8'hF8,   1,  1,   1};
    vecs[3] = '{"boundary",     8'h00, 8'h03, 8'hE0, 8'hF8,   0,  0,   1};
    vecs[4] = '{"ones_pat11111",8'hFF, 8'hFF, 8'hFF, 8'hF8, 128, 32, 252};
    vecs[5] = '{"zeros_pat1s",  8'h00, 8'h00, 8'h00, 8'hF8,   0,  0,   0};

    reset = 1'b1;
    start = 1'b0;
    build(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    check("rst busy",    int'(busy), 0);
    check("rst done",    int'(done), 0);
    check("rst wr_en",   int'(mem_wr_en), 0);
    check("rst addr",    int'(mem_addr), 0);
    check("rst wr_data", int'(mem_wr_data), 0);

    // start in the same cycle as reset is ignored.
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst+start busy", int'(busy), 0);
    @(negedge clk);
    check("rst+start still idle", int'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      build(vecs[v].fill, vecs[v].b0, vecs[v].b1, vecs[v].pat_byte);
      run_job(vecs[v].name, vecs[v].ctb, vecs[v].cto, vecs[v].cts, 1'b0);
    end

    // Restart from DONE after an all-zero result; counters must start fresh.
    check("pre-restart done", int'(done), 1);
    build(8'h00, 8'h00, 8'h00, 8'h00);
    run_job("restart", 128, 32, 252, 1'b0);

    // Reset in the 10th SCAN cycle (state after rising edge 11 counted from start).
    build(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    edges = 1;
    while (edges < 11) begin
      @(negedge clk);
      edges++;
    end
    check("midscan busy", int'(busy), 1);
    check("midscan addr", int'(mem_addr), 9);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy",  int'(busy), 0);
    check("abort done",  int'(done), 0);
    check("abort wr_en", int'(mem_wr_en), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort mem33", int'(mem[33]), 8'hEE);
    check("abort mem34", int'(mem[34]), 8'hEE);
    check("abort mem35", int'(mem[35]), 8'hEE);
    check("abort writes", wr_count, 0);
    check("abort idle", int'(busy), 0);

    // Restarted run with a stray start pulse mid-SCAN.
    build(8'h00, 8'h00, 8'h00, 8'h00);
    run_job("after_reset", 128, 32, 252, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
